quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
- Upstream front-end for the UP_DOWN_COUNTER instances.
- Takes the two raw, asynchronous quadrature channels (A/B) from a rotary encoder and produces the counter's EN and UP_DWN controls.
- Synchronises and glitch-filters each channel, then decodes Gray-code phase steps into single-cycle count strobes with direction.
- Detects illegal double-bit jumps and counts them.

Parameters:
- FILTER_LEN, 4, consecutive cycles a synchronised channel must differ from its filtered value before the filtered value updates; legal range >= 1.
- ERR_CNT_W, 8, width of the saturating illegal-transition counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- N_RST  input  1  asynchronous active-low reset.
- QA  input  1  raw encoder channel A; asynchronous to CLK.
- QB  input  1  raw encoder channel B; asynchronous to CLK.
- CLR_ERR  input  1  synchronous clear of ERR_CNT.
- EN  output  1  one-cycle count strobe; connects to counter EN.
- UP_DWN  output  1  direction, 1 = up; valid when EN = 1 and holds its last value otherwise.
- ERR  output  1  one-cycle pulse on an illegal transition.
- ERR_CNT  output  ERR_CNT_W  saturating count of illegal transitions.

Behaviour:
- Reset (N_RST low, immediate): sync flops, filtered values, filter counters, phase register = 0; EN = 0, UP_DWN = 0, ERR = 0, ERR_CNT = 0. Settle counter is loaded.
- Synchroniser: two flops per channel.
- Filter (per channel):
  - At each edge where sync2 != filt, the counter increments.
  - On the FILTER_LEN-th consecutive such edge, filt <= sync2 and the counter is cleared.
  - At any edge where sync2 == filt, the counter is cleared.
  - Pulses shorter than FILTER_LEN cycles are rejected.
- Phase encoding {A,B}; forward (up) sequence is 00 -> 10 -> 11 -> 01 -> 00.
- Decoder, evaluated each edge by comparing filtered {A,B} against the phase register:
  - Equal: EN = 0, ERR = 0.
  - One forward step: EN = 1, UP_DWN = 1 for exactly one cycle; phase register updates.
  - One backward step: EN = 1, UP_DWN = 0; phase register updates.
  - Both bits changed: EN = 0, ERR = 1 for one cycle, ERR_CNT increments (saturates at all-ones), phase register takes the new value.
- Outputs EN, UP_DWN, ERR are registered.
- Latency: edge 1 is the first edge sampling a new stable input level.
  - sync2 valid at edge 2.
  - Filtered value updates at edge FILTER_LEN+2.
  - EN/ERR asserted after edge FILTER_LEN+3 and deasserted after the next edge.
  - For FILTER_LEN = 4: strobe after edge 7.
- Steps closer than FILTER_LEN+1 cycles apart are not guaranteed to be decoded; minimum legal step spacing is FILTER_LEN+1 cycles.
- Settle:
  - For FILTER_LEN+3 cycles after N_RST deasserts, the phase register tracks filtered {A,B} every cycle.
  - EN and ERR are held 0 and ERR_CNT does not change during settle.
  - Purpose: absorbs non-00 encoder position at power-up/reset without a false ERR.
- CLR_ERR: ERR_CNT <= 0. Clear has priority over a same-cycle increment; ERR still pulses.
- Reset mid-operation: all state cleared immediately, including any in-flight EN pulse; settle restarts on release.

Decomposition:
- Package quad_pkg:
  - typedef enum logic [1:0] phase_t: PH00, PH10, PH11, PH01.
  - Functions fwd_next(phase_t) and bwd_next(phase_t).
  - Localparam SETTLE_CYC = FILTER_LEN+3 is computed in quad_decoder, since it depends on the instance parameter.
- Sub-module quad_filter (parameter FILTER_LEN): 2-flop synchroniser plus stability counter for one channel, instantiated twice.
- Decode FSM, settle counter and error counter live in quad_decoder.

Test Plan:
1. Reset with QA = QB = 0, wait settle, set QA = 1 -> EN = 1, UP_DWN = 1 for one cycle exactly after edge 7 (FILTER_LEN = 4); ERR = 0.
2. Full forward cycle 00->10->11->01->00, steps 10 cycles apart -> 4 EN pulses all UP_DWN = 1; then reverse 00->01->11->10->00 -> 4 EN pulses all UP_DWN = 0; UP_DWN holds 0 after.
3. Glitch: QA high for 3 cycles then low -> no EN, no ERR; QA high for 4 cycles -> one EN up strobe, then one EN down strobe after it falls.
4. Illegal: from 00, QA and QB rise in same cycle -> ERR one cycle, ERR_CNT = 1, EN = 0; assert CLR_ERR -> ERR_CNT = 0. With ERR_CNT_W = 2, five illegal jumps -> ERR_CNT = 3.
5. Startup at position 11 (QA = QB = 1 during and after reset) -> no ERR, no EN through settle; then QA = 0 (11->01 forward) -> EN = 1, UP_DWN = 1.
6. N_RST pulsed low one cycle after a valid step, before its strobe -> outputs 0 immediately, no EN emitted, ERR_CNT = 0, settle restarts.

Source files
------------

// File: rtl/quad_pkg.sv
// ---------------------------------------------------------------------------
// quad_pkg
// Shared types and helpers for the quadrature decoder.
//   phase_t  : encoder phase encoded as {A,B}
//   fwd_next : phase reached by one step in the up direction
//   bwd_next : phase reached by one step in the down direction
// Up sequence: 00 -> 10 -> 11 -> 01 -> 00.
// ---------------------------------------------------------------------------
package quad_pkg;

    typedef enum logic [1:0] {
        PH00 = 2'b00,
        PH01 = 2'b01,
        PH10 = 2'b10,
        PH11 = 2'b11
    } phase_t;

    function automatic phase_t fwd_next(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH00:    nxt = PH10;
            PH10:    nxt = PH11;
            PH11:    nxt = PH01;
            default: nxt = PH00;
        endcase
        return nxt;
    endfunction

    function automatic phase_t bwd_next(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH00:    nxt = PH01;
            PH01:    nxt = PH11;
            PH11:    nxt = PH10;
            default: nxt = PH00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// ---------------------------------------------------------------------------
// quad_decoder_if
// Signal bundle between the encoder side and the counter side.
//   QA, QB   : raw encoder channels (asynchronous)
//   CLR_ERR  : synchronous clear of the illegal-transition counter
//   EN       : one-cycle count strobe
//   UP_DWN   : direction, 1 = up; holds its last value between strobes
//   ERR      : one-cycle pulse on an illegal double-bit jump
//   ERR_CNT  : saturating illegal-transition count
// master drives the encoder inputs, slave is the decoder.
// ---------------------------------------------------------------------------
interface quad_decoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 QA;
    logic                 QB;
    logic                 CLR_ERR;
    logic                 EN;
    logic                 UP_DWN;
    logic                 ERR;
    logic [ERR_CNT_W-1:0] ERR_CNT;

    modport master (
        output QA, QB, CLR_ERR,
        input  EN, UP_DWN, ERR, ERR_CNT
    );

    modport slave (
        input  QA, QB, CLR_ERR,
        output EN, UP_DWN, ERR, ERR_CNT
    );
endinterface

// File: rtl/quad_filter.sv
// ---------------------------------------------------------------------------
// quad_filter
// One encoder channel: two-flop synchroniser followed by a stability filter.
// The filtered value follows the synchronised value only after it has
// differed for FILTER_LEN consecutive edges; shorter pulses are dropped.
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   raw   : asynchronous channel input
//   filt  : synchronised, de-glitched channel value
// ---------------------------------------------------------------------------
module quad_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw,
    output logic filt
);

    // Counter only has to reach FILTER_LEN-1; the FILTER_LEN-th edge commits.
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1;
    logic             sync2;
    logic             filt_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            filt_q <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != filt_q) begin
                if (cnt == CNT_LAST) begin
                    filt_q <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                // Any agreement breaks the run, so the count restarts.
                cnt <= '0;
            end
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
// Rotary-encoder front end for the up/down counter. Filters both channels,
// decodes Gray-code phase steps into registered count strobes with
// direction, and flags/counts illegal double-bit jumps.
//   CLK      : system clock, rising edge
//   N_RST    : asynchronous active-low reset
//   bus      : quad_decoder_if slave (QA/QB/CLR_ERR in, EN/UP_DWN/ERR/ERR_CNT out)
// After reset release the phase register shadows the filtered inputs for
// SETTLE_CYC cycles so a non-00 power-up position is not reported as a jump.
// ---------------------------------------------------------------------------
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic          CLK,
    input  logic          N_RST,
    quad_decoder_if.slave bus
);

    // Covers synchroniser (2) + filter (FILTER_LEN) + one decode edge.
    localparam int SETTLE_CYC = FILTER_LEN + 3;
    localparam int SETTLE_W   = $clog2(SETTLE_CYC + 1);

    logic filt_a;
    logic filt_b;

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk   (CLK),
        .n_rst (N_RST),
        .raw   (bus.QA),
        .filt  (filt_a)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk   (CLK),
        .n_rst (N_RST),
        .raw   (bus.QB),
        .filt  (filt_b)
    );

    phase_t               phase_q;
    phase_t               phase_nxt;
    phase_t               cur;
    logic                 en_q;
    logic                 en_nxt;
    logic                 up_q;
    logic                 up_nxt;
    logic                 err_q;
    logic                 err_nxt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 settling;

    assign cur      = phase_t'({filt_a, filt_b});
    assign settling = (settle_cnt != '0);

    always_comb begin
        phase_nxt = cur;
        en_nxt    = 1'b0;
        up_nxt    = up_q;
        err_nxt   = 1'b0;
        if (!settling && (cur != phase_q)) begin
            if (cur == fwd_next(phase_q)) begin
                en_nxt = 1'b1;
                up_nxt = 1'b1;
            end else if (cur == bwd_next(phase_q)) begin
                en_nxt = 1'b1;
                up_nxt = 1'b0;
            end else begin
                // Both bits moved: direction is unknowable, resync to new phase.
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            phase_q    <= PH00;
            en_q       <= 1'b0;
            up_q       <= 1'b0;
            err_q      <= 1'b0;
            settle_cnt <= SETTLE_W'(SETTLE_CYC);
            err_cnt    <= '0;
        end else begin
            phase_q <= phase_nxt;
            en_q    <= en_nxt;
            up_q    <= up_nxt;
            err_q   <= err_nxt;
            if (settling) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            // Clear wins over a coincident increment; ERR still pulses.
            if (bus.CLR_ERR) begin
                err_cnt <= '0;
            end else if (err_nxt && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign bus.EN      = en_q;
    assign bus.UP_DWN  = up_q;
    assign bus.ERR     = err_q;
    assign bus.ERR_CNT = err_cnt;

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder
// Two decoder instances share the same inputs: one with a 2-bit error
// counter (saturation visible quickly) and one with the default 8-bit width.
// Stimulus pushes expected events into a queue; a negedge monitor pops and
// compares EN/ERR/UP_DWN/ERR_CNT every cycle.
// ---------------------------------------------------------------------------
module tb_quad_decoder;

    localparam int FL     = 4;
    localparam int NW     = 2;
    localparam int WW     = 8;
    localparam int NMAX   = (1 << NW) - 1;
    localparam int WMAX   = (1 << WW) - 1;
    localparam int LAT    = FL + 3;
    localparam int SETTLE = FL + 3;

    logic clk;
    logic n_rst;

    quad_decoder_if #(.ERR_CNT_W(NW)) bus_n ();
    quad_decoder_if #(.ERR_CNT_W(WW)) bus_w ();

    assign bus_w.QA      = bus_n.QA;
    assign bus_w.QB      = bus_n.QB;
    assign bus_w.CLR_ERR = bus_n.CLR_ERR;

    quad_decoder #(.FILTER_LEN(FL), .ERR_CNT_W(NW)) dut_n (
        .CLK   (clk),
        .N_RST (n_rst),
        .bus   (bus_n)
    );

    quad_decoder #(.FILTER_LEN(FL), .ERR_CNT_W(WW)) dut_w (
        .CLK   (clk),
        .N_RST (n_rst),
        .bus   (bus_w)
    );

    typedef struct {
        int cyc;
        bit is_err;
        bit up;
        int cnt_n;
        int cnt_w;
    } ev_t;

    ev_t sb[$];
    int  cyc         = 0;
    int  vectors     = 0;
    int  miscompares = 0;
    int  pos         = 0;
    int  err_total   = 0;
    bit  exp_dir     = 1'b0;

    // Positions around the encoder circle in the up direction, as {A,B}.
    bit [1:0] ring [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int pos_of(input bit a, input bit b);
        for (int i = 0; i < 4; i++) begin
            if (ring[i] == {a, b}) return i;
        end
        return 0;
    endfunction

    function automatic int sat(input int t, input int m);
        return (t > m) ? m : t;
    endfunction

    // Monitor: expected outputs each cycle derived from the event queue.
    always @(negedge clk) begin : monitor
        ev_t e;
        bit  x_en;
        bit  x_err;
        if (!n_rst) begin
            exp_dir = 1'b0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed_event: nothing seen, required event at cycle %0d (now %0d)", e.cyc, cyc);
            end
            x_en  = 1'b0;
            x_err = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e     = sb.pop_front();
                x_en  = !e.is_err;
                x_err = e.is_err;
                if (!e.is_err) exp_dir = e.up;
            end
            check("en", bus_n.EN, x_en);
            check("err", bus_n.ERR, x_err);
            check("up_dwn", bus_n.UP_DWN, exp_dir);
            check("en_w", bus_w.EN, x_en);
            check("err_w", bus_w.ERR, x_err);
            check("up_dwn_w", bus_w.UP_DWN, exp_dir);
            if (x_err) begin
                check("err_cnt_at_err", bus_n.ERR_CNT, e.cnt_n);
                check("err_cnt_w_at_err", bus_w.ERR_CNT, e.cnt_w);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Move the encoder to {a,b}; called at a negedge.
    task automatic apply(input bit a, input bit b, input bit clr_at_strobe = 1'b0);
        int  np;
        int  d;
        ev_t e;
        np       = pos_of(a, b);
        d        = (np - pos + 4) % 4;
        e.cyc    = cyc + LAT;
        e.up     = (d == 1);
        e.is_err = (d == 2);
        e.cnt_n  = 0;
        e.cnt_w  = 0;
        if (d == 2) begin
            err_total++;
            if (clr_at_strobe) err_total = 0;
            e.cnt_n = sat(err_total, NMAX);
            e.cnt_w = sat(err_total, WMAX);
        end
        if (d != 0) sb.push_back(e);
        pos      = np;
        bus_n.QA = a;
        bus_n.QB = b;
        if (clr_at_strobe) begin
            wait_cyc(LAT - 1);
            bus_n.CLR_ERR = 1'b1;
            wait_cyc(1);
            bus_n.CLR_ERR = 1'b0;
        end
    endtask

    task automatic glitch(input bit on_a, input int len);
        if (on_a) bus_n.QA = ~bus_n.QA;
        else      bus_n.QB = ~bus_n.QB;
        wait_cyc(len);
        if (on_a) bus_n.QA = ~bus_n.QA;
        else      bus_n.QB = ~bus_n.QB;
    endtask

    task automatic check_cnt();
        check("err_cnt", bus_n.ERR_CNT, sat(err_total, NMAX));
        check("err_cnt_w", bus_w.ERR_CNT, sat(err_total, WMAX));
    endtask

    task automatic clear_err();
        bus_n.CLR_ERR = 1'b1;
        wait_cyc(1);
        bus_n.CLR_ERR = 1'b0;
        err_total     = 0;
    endtask

    task automatic do_reset(input bit a, input bit b);
        bus_n.QA = a;
        bus_n.QB = b;
        @(posedge clk);
        #1 n_rst = 1'b0;
        sb.delete();
        err_total = 0;
        pos       = pos_of(a, b);
        #1;
        check("rst_en", bus_n.EN, 0);
        check("rst_err", bus_n.ERR, 0);
        check("rst_up_dwn", bus_n.UP_DWN, 0);
        check("rst_err_cnt", bus_n.ERR_CNT, 0);
        check("rst_err_cnt_w", bus_w.ERR_CNT, 0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        wait_cyc(SETTLE + 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 50000 cycles");
        $fatal(1);
    end

    initial begin
        int r;
        int np;
        n_rst         = 1'b0;
        bus_n.QA      = 1'b0;
        bus_n.QB      = 1'b0;
        bus_n.CLR_ERR = 1'b0;
        wait_cyc(2);

        // Single up step from 00, then a full forward and reverse cycle.
        do_reset(1'b0, 1'b0);
        apply(1'b1, 1'b0); wait_cyc(10);
        apply(1'b1, 1'b1); wait_cyc(10);
        apply(1'b0, 1'b1); wait_cyc(10);
        apply(1'b0, 1'b0); wait_cyc(10);
        apply(1'b0, 1'b1); wait_cyc(10);
        apply(1'b1, 1'b1); wait_cyc(10);
        apply(1'b1, 1'b0); wait_cyc(10);
        apply(1'b0, 1'b0); wait_cyc(15);

        // Glitches: 3-cycle pulse rejected, 4-cycle pulse gives up then down.
        glitch(1'b1, FL - 1); wait_cyc(12);
        pos = pos_of(1'b1, 1'b0);
        sb.push_back('{cyc + LAT, 1'b0, 1'b1, 0, 0});
        bus_n.QA = 1'b1;
        wait_cyc(FL);
        apply(1'b0, 1'b0); wait_cyc(15);

        // Illegal jumps, clear, saturation, clear-vs-increment priority.
        apply(1'b1, 1'b1); wait_cyc(10);
        check_cnt();
        clear_err();
        check_cnt();
        apply(1'b0, 1'b0); wait_cyc(10);
        apply(1'b1, 1'b1); wait_cyc(10);
        apply(1'b0, 1'b0); wait_cyc(10);
        apply(1'b1, 1'b1); wait_cyc(10);
        apply(1'b0, 1'b0); wait_cyc(10);
        check_cnt();
        apply(1'b1, 1'b1, 1'b1); wait_cyc(10);
        check_cnt();

        // Start-up at position 11, then 11 -> 01 is an up step.
        do_reset(1'b1, 1'b1);
        check_cnt();
        apply(1'b0, 1'b1); wait_cyc(12);

        // Reset lands between a step and its strobe: strobe is lost.
        apply(1'b0, 1'b0); wait_cyc(12);
        apply(1'b1, 1'b0);
        wait_cyc(1);
        do_reset(1'b1, 1'b0);
        check_cnt();
        apply(1'b1, 1'b1); wait_cyc(12);

        // Randomised walk with glitches and occasional clears.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                glitch(r[0], $urandom_range(1, FL - 1));
                wait_cyc(FL + 3);
            end else if (r == 2) begin
                wait_cyc(LAT + 2);
                check_cnt();
                clear_err();
                check_cnt();
            end else begin
                np = $urandom_range(0, 3);
                apply(ring[np][1], ring[np][0]);
                wait_cyc($urandom_range(FL + 1, FL + 6));
            end
        end

        wait_cyc(LAT + 10);
        check_cnt();
        check("pending_events", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
